// File: rtl/pi_req_queue_if.sv
// rtl/pi_req_queue_if.sv - upstream, timing-side and status signals of the Pi request queue
interface pi_req_queue_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          up_valid_i;
   logic          up_ready_o;
   logic          up_rw_b_i;
   logic [16:0]   up_addr_i;
   logic [7:0]    up_data_i;
   logic          flush_i;
   logic          pi_pending_o;
   logic          pi_rw_b_o;
   logic [16:0]   pi_addr_o;
   logic [7:0]    pi_data_o;
   logic          pi_done_i;
   logic [7:0]    rd_data_i;
   logic          rd_valid_o;
   logic [7:0]    rd_data_o;
   logic [LW-1:0] level_o;
   logic          busy_o;
   logic          err_o;

   modport slave (
      input  up_valid_i, up_rw_b_i, up_addr_i, up_data_i, flush_i, pi_done_i, rd_data_i,
      output up_ready_o, pi_pending_o, pi_rw_b_o, pi_addr_o, pi_data_o,
      output rd_valid_o, rd_data_o, level_o, busy_o, err_o
   );

   modport master (
      output up_valid_i, up_rw_b_i, up_addr_i, up_data_i, flush_i, pi_done_i, rd_data_i,
      input  up_ready_o, pi_pending_o, pi_rw_b_o, pi_addr_o, pi_data_o,
      input  rd_valid_o, rd_data_o, level_o, busy_o, err_o
   );
endinterface

// File: rtl/pi_req_queue.sv
// rtl/pi_req_queue.sv - FIFO of Pi bus requests issued one at a time to the timing sequencer
module pi_req_queue #(
   parameter int DEPTH = 4
) (
   input logic           clk_16_i,
   input logic           reset_ni,
   pi_req_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t      state;
   logic [25:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] level;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic [25:0] head;

   assign level = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A flush wins over both a same-cycle push and a same-cycle pop.
   assign push  = bus.up_valid_i && !full && !bus.flush_i;
   assign pop   = (state == IDLE) && !empty && !bus.flush_i;
   assign head  = mem[rd_ptr[AW-1:0]];

   assign bus.up_ready_o = !full;
   assign bus.level_o    = level;
   assign bus.busy_o     = (level != '0) || (state != IDLE);

   always_ff @(posedge clk_16_i) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {bus.up_rw_b_i, bus.up_addr_i, bus.up_data_i};
      end
   end

   always_ff @(posedge clk_16_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (bus.flush_i) begin
            rd_ptr <= wr_ptr;
         end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_16_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state            <= IDLE;
         bus.pi_pending_o <= 1'b0;
         bus.pi_rw_b_o    <= 1'b1;
         bus.pi_addr_o    <= '0;
         bus.pi_data_o    <= '0;
         bus.rd_valid_o   <= 1'b0;
         bus.rd_data_o    <= '0;
         bus.err_o        <= 1'b0;
      end else begin
         bus.rd_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.pi_done_i) begin
                  bus.err_o <= 1'b1;
               end
               if (pop) begin
                  bus.pi_rw_b_o    <= head[25];
                  bus.pi_addr_o    <= head[24:8];
                  bus.pi_data_o    <= head[7:0];
                  bus.pi_pending_o <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.pi_done_i) begin
                  bus.pi_pending_o <= 1'b0;
                  if (bus.pi_rw_b_o) begin
                     bus.rd_data_o  <= bus.rd_data_i;
                     bus.rd_valid_o <= 1'b1;
                  end
                  state <= GAP;
               end
            end
            GAP: begin
               // One low cycle of pending so the timing block sees a fresh edge per request.
               if (bus.pi_done_i) begin
                  bus.err_o <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
